// File: rtl/vga_timing_if.sv
// Raster timing bundle carried from the timing generator to the pixel pipeline.
// The master drives counts and flags; every downstream stage consumes it as slave.
interface vga_timing_if;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic        frame_start;

    modport master (
        output hcount_out,
        output vcount_out,
        output hsync_out,
        output vsync_out,
        output hblnk_out,
        output vblnk_out,
        output frame_start
    );

    modport slave (
        input hcount_out,
        input vcount_out,
        input hsync_out,
        input vsync_out,
        input hblnk_out,
        input vblnk_out,
        input frame_start
    );
endinterface

// File: rtl/vga_timing.sv
// Free-running raster timing generator (1024x768@60 by default) with registered,
// zero-skew counts and flags: each flag is derived from the next counter values.
module vga_timing #(
    parameter int H_VISIBLE = 1024,
    parameter int H_FRONT   = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BACK    = 160,
    parameter int V_VISIBLE = 768,
    parameter int V_FRONT   = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BACK    = 29
) (
    input  logic         clk,
    input  logic         rst,
    vga_timing_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_BLNK_START = 11'(H_VISIBLE);
    localparam logic [10:0] V_BLNK_START = 11'(V_VISIBLE);
    localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_SYNC_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    // Half-open window test [lo, hi)
    function automatic logic f_in_window(
        input logic [10:0] value,
        input logic [10:0] lo,
        input logic [10:0] hi
    );
        return (value >= lo) && (value < hi);
    endfunction

    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_hblnk;
    logic        r_vblnk;
    logic        r_frame_start;

    logic [10:0] w_hcount_nxt;
    logic [10:0] w_vcount_nxt;

    // Wrap on >= so an out-of-range count can never run away
    always_comb begin
        w_hcount_nxt = r_hcount + 11'd1;
        w_vcount_nxt = r_vcount;
        if (r_hcount >= H_LAST) begin
            w_hcount_nxt = '0;
            if (r_vcount >= V_LAST) begin
                w_vcount_nxt = '0;
            end else begin
                w_vcount_nxt = r_vcount + 11'd1;
            end
        end
    end

    // frame_start sits high in reset: (0,0) is the first pixel after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_frame_start <= 1'b1;
        end else begin
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_hblnk       <= (w_hcount_nxt >= H_BLNK_START);
            r_vblnk       <= (w_vcount_nxt >= V_BLNK_START);
            r_hsync       <= f_in_window(w_hcount_nxt, H_SYNC_START, H_SYNC_END);
            r_vsync       <= f_in_window(w_vcount_nxt, V_SYNC_START, V_SYNC_END);
            r_frame_start <= (w_hcount_nxt == 11'd0) && (w_vcount_nxt == 11'd0);
        end
    end

    assign vga.hcount_out  = r_hcount;
    assign vga.vcount_out  = r_vcount;
    assign vga.hsync_out   = r_hsync;
    assign vga.vsync_out   = r_vsync;
    assign vga.hblnk_out   = r_hblnk;
    assign vga.vblnk_out   = r_vblnk;
    assign vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a full-size XGA instance for line-level behaviour and a
// reduced-geometry instance so complete frames fit in a short run.
module tb_vga_timing;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        fs;
    } vga_t;

    // Reduced geometry for the second instance: 25 x 18 = 450 cycles per frame
    localparam int BHV = 16, BHF = 2, BHS = 3, BHB = 4;
    localparam int BVV = 12, BVF = 1, BVS = 2, BVB = 3;
    localparam int BHT = BHV + BHF + BHS + BHB;
    localparam int BVT = BVV + BVF + BVS + BVB;
    localparam int AHT = 1344, AVT = 806;

    logic clk;
    logic rst_a;
    logic rst_b;

    vga_timing_if vif_a ();
    vga_timing_if vif_b ();

    vga_timing dut_a (
        .clk (clk),
        .rst (rst_a),
        .vga (vif_a)
    );

    vga_timing #(
        .H_VISIBLE (BHV), .H_FRONT (BHF), .H_SYNC (BHS), .H_BACK (BHB),
        .V_VISIBLE (BVV), .V_FRONT (BVF), .V_SYNC (BVS), .V_BACK (BVB)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .vga (vif_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_chk = 0;
    int   n_err = 0;
    int   mh_a = 0, mv_a = 0, mh_b = 0, mv_b = 0;
    vga_t q_a[$];
    vga_t q_b[$];

    function automatic vga_t mk(input int h, input int v,
                                input int hv, input int hf, input int hsw,
                                input int vv, input int vf, input int vsw);
        vga_t r;
        r.h  = 11'(h);
        r.v  = 11'(v);
        r.hb = (h >= hv);
        r.vb = (v >= vv);
        r.hs = (h >= hv + hf) && (h < hv + hf + hsw);
        r.vs = (v >= vv + vf) && (v < vv + vf + vsw);
        r.fs = (h == 0) && (v == 0);
        return r;
    endfunction

    function automatic vga_t rst_tuple();
        vga_t r;
        r    = '0;
        r.fs = 1'b1;
        return r;
    endfunction

    function automatic vga_t exp_a();
        if (rst_a) return rst_tuple();
        return mk(mh_a, mv_a, 1024, 24, 136, 768, 3, 6);
    endfunction

    function automatic vga_t exp_b();
        if (rst_b) return rst_tuple();
        return mk(mh_b, mv_b, BHV, BHF, BHS, BVV, BVF, BVS);
    endfunction

    function automatic vga_t obs_a();
        return '{vif_a.hcount_out, vif_a.vcount_out, vif_a.hsync_out, vif_a.vsync_out,
                 vif_a.hblnk_out, vif_a.vblnk_out, vif_a.frame_start};
    endfunction

    function automatic vga_t obs_b();
        return '{vif_b.hcount_out, vif_b.vcount_out, vif_b.hsync_out, vif_b.vsync_out,
                 vif_b.hblnk_out, vif_b.vblnk_out, vif_b.frame_start};
    endfunction

    task automatic chk(input string tag, input vga_t got, input vga_t exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b, expected h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b",
                   tag, got.h, got.v, got.hs, got.vs, got.hb, got.vb, got.fs,
                   exp.h, exp.v, exp.hs, exp.vs, exp.hb, exp.vb, exp.fs);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Pop the scoreboard for both instances and compare against the outputs
    task automatic pop_check();
        chk("cycle_a", obs_a(), q_a.pop_front());
        chk("cycle_b", obs_b(), q_b.pop_front());
    endtask

    task automatic check_now();
        q_a.push_back(exp_a());
        q_b.push_back(exp_b());
        pop_check();
    endtask

    // One clock: advance the reference counters, queue expectations, compare 1 ns later
    task automatic step();
        @(posedge clk);
        if (!rst_a) begin
            if (mh_a == AHT - 1) begin
                mh_a = 0;
                mv_a = (mv_a == AVT - 1) ? 0 : mv_a + 1;
            end else begin
                mh_a++;
            end
        end
        if (!rst_b) begin
            if (mh_b == BHT - 1) begin
                mh_b = 0;
                mv_b = (mv_b == BVT - 1) ? 0 : mv_b + 1;
            end else begin
                mh_b++;
            end
        end
        q_a.push_back(exp_a());
        q_b.push_back(exp_b());
        #1;
        pop_check();
    endtask

    task automatic run_a_to(input int h, input int v);
        int guard = 0;
        while (!(mh_a == h && mv_a == v) && guard < 40000) begin
            step();
            guard++;
        end
        chk_int("reach_a_h", int'(vif_a.hcount_out), h);
        chk_int("reach_a_v", int'(vif_a.vcount_out), v);
    endtask

    task automatic run_b_to(input int h, input int v);
        int guard = 0;
        while (!(mh_b == h && mv_b == v) && guard < 2000) begin
            step();
            guard++;
        end
        chk_int("reach_b_h", int'(vif_b.hcount_out), h);
        chk_int("reach_b_v", int'(vif_b.vcount_out), v);
    endtask

    initial begin
        int   ones;
        int   gap;
        int   mism;
        vga_t d;

        rst_a = 1'b1;
        rst_b = 1'b1;
        #3;
        check_now();
        chk_int("rst_fs_a", int'(vif_a.frame_start), 1);
        step();
        step();
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        step();
        chk_int("rel_h_a", int'(vif_a.hcount_out), 1);
        chk_int("rel_v_a", int'(vif_a.vcount_out), 0);
        chk_int("rel_fs_a", int'(vif_a.frame_start), 0);

        // Line 0 horizontal blanking and sync window
        run_a_to(1023, 0);
        chk_int("hblnk_1023", int'(vif_a.hblnk_out), 0);
        step();
        chk_int("hblnk_1024", int'(vif_a.hblnk_out), 1);
        run_a_to(1047, 0);
        chk_int("hsync_1047", int'(vif_a.hsync_out), 0);
        ones = 0;
        for (int i = 1048; i <= 1183; i++) begin
            step();
            if (vif_a.hsync_out === 1'b1) ones++;
        end
        chk_int("hsync_ones_1048_1183", ones, 136);
        step();
        chk_int("hsync_1184", int'(vif_a.hsync_out), 0);

        // Line wrap on line 10
        run_a_to(1343, 10);
        chk_int("hblnk_1343", int'(vif_a.hblnk_out), 1);
        step();
        chk_int("wrap_h", int'(vif_a.hcount_out), 0);
        chk_int("wrap_v", int'(vif_a.vcount_out), 11);
        chk_int("wrap_hblnk", int'(vif_a.hblnk_out), 0);

        // Asynchronous reset mid-line, between edges
        run_a_to(500, 11);
        #2;
        rst_a = 1'b1;
        mh_a  = 0;
        mv_a  = 0;
        #1;
        check_now();
        chk_int("async_rst_h", int'(vif_a.hcount_out), 0);
        chk_int("async_rst_fs", int'(vif_a.frame_start), 1);
        step();
        @(negedge clk);
        rst_a = 1'b0;
        step();
        chk_int("rerel_h", int'(vif_a.hcount_out), 1);
        chk_int("rerel_v", int'(vif_a.vcount_out), 0);
        chk_int("rerel_fs", int'(vif_a.frame_start), 0);

        // Vertical flags on the reduced instance (vsync on lines 13..14)
        run_b_to(BHT - 1, BVV - 1);
        chk_int("vblnk_before", int'(vif_b.vblnk_out), 0);
        step();
        chk_int("vblnk_rise", int'(vif_b.vblnk_out), 1);
        run_b_to(BHT - 1, BVV);
        chk_int("vsync_line12", int'(vif_b.vsync_out), 0);
        ones = 0;
        for (int i = 0; i < 2 * BHT; i++) begin
            step();
            if (vif_b.vsync_out === 1'b1) ones++;
        end
        chk_int("vsync_ones_two_lines", ones, 2 * BHT);
        step();
        chk_int("vsync_line15", int'(vif_b.vsync_out), 0);

        // Frame wrap and frame_start spacing over three frames
        run_b_to(BHT - 1, BVT - 1);
        chk_int("fs_before_wrap", int'(vif_b.frame_start), 0);
        step();
        chk_int("fwrap_h", int'(vif_b.hcount_out), 0);
        chk_int("fwrap_v", int'(vif_b.vcount_out), 0);
        chk_int("fwrap_fs", int'(vif_b.frame_start), 1);
        for (int k = 0; k < 3; k++) begin
            gap = 0;
            do begin
                step();
                gap++;
            end while (vif_b.frame_start !== 1'b1 && gap < 1000);
            chk_int("fs_period", gap, BHT * BVT);
        end
        step();
        chk_int("fs_one_cycle", int'(vif_b.frame_start), 0);

        // Flags against the definitions applied to the same cycle's counts
        mism = 0;
        for (int i = 0; i < BHT * BVT; i++) begin
            step();
            d = mk(int'(vif_b.hcount_out), int'(vif_b.vcount_out), BHV, BHF, BHS, BVV, BVF, BVS);
            if ({vif_b.hsync_out, vif_b.vsync_out, vif_b.hblnk_out, vif_b.vblnk_out, vif_b.frame_start}
                !== {d.hs, d.vs, d.hb, d.vb, d.fs}) mism++;
        end
        chk_int("flag_consistency", mism, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
